// File: rtl/time_seq_ctrl.sv
// Sequencer for HH:MM:SS BCD digit registers: 1 Hz tick -> inc/clr strobes, plus set-time FSM.
// Strobes registered one cycle after their cause; one busy settle cycle follows each strobe.
module time_seq_ctrl #(
   parameter int REPEAT_CYCLES = 8,
   parameter int TIMEOUT_TICKS = 10
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       tick,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic [3:0] hr_t,
   input  logic [3:0] hr_u,
   input  logic [3:0] mn_t,
   input  logic [3:0] mn_u,
   input  logic [3:0] sc_t,
   input  logic [3:0] sc_u,
   output logic [5:0] inc,
   output logic [5:0] clr,
   output logic [1:0] mode,
   output logic       busy
);

   localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);

   typedef enum logic [1:0] {RUN = 2'd0, SET_HR = 2'd1, SET_MN = 2'd2} state_t;

   state_t        state_q, state_d;
   logic [5:0]    inc_d, clr_d;
   logic          up_q;
   logic [RW-1:0] rep_q;
   logic [TW-1:0] to_q;
   logic          tick_pend_q;

   logic up_rise, rep_hit, mode_ev, run_tick, set_tick, timeout, step;
   logic [1:0] h_inc, h_clr, m_inc, m_clr, s_inc, s_clr;
   logic       m_carry, s_carry;

   assign mode     = state_q;
   assign up_rise  = btn_up & ~up_q;
   assign rep_hit  = btn_up & up_q & (rep_q == RW'(REPEAT_CYCLES - 1));
   assign mode_ev  = btn_mode & ~busy;
   assign run_tick = (state_q == RUN) & (tick | tick_pend_q) & ~busy;
   assign set_tick = (state_q != RUN) & tick;
   assign timeout  = set_tick & ~btn_mode & ~btn_up & (to_q == TW'(TIMEOUT_TICKS - 1));
   assign step     = (state_q != RUN) & (up_rise | rep_hit) & ~btn_mode & ~busy;

   // Per-field advance decisions, shared by the tick path and the set path
   always_comb begin
      h_inc = 2'b00;
      h_clr = 2'b00;
      if (hr_t == 4'd2 && hr_u >= 4'd3) begin
         h_clr = 2'b11;
      end else if (hr_u >= 4'd9) begin
         h_clr = 2'b01;
         h_inc = 2'b10;
      end else begin
         h_inc = 2'b01;
      end
      m_inc   = 2'b00;
      m_clr   = 2'b00;
      m_carry = 1'b0;
      if (mn_u >= 4'd9) begin
         m_clr[0] = 1'b1;
         if (mn_t >= 4'd5) begin
            m_clr[1] = 1'b1;
            m_carry  = 1'b1;
         end else begin
            m_inc[1] = 1'b1;
         end
      end else begin
         m_inc[0] = 1'b1;
      end
      s_inc   = 2'b00;
      s_clr   = 2'b00;
      s_carry = 1'b0;
      if (sc_u >= 4'd9) begin
         s_clr[0] = 1'b1;
         if (sc_t >= 4'd5) begin
            s_clr[1] = 1'b1;
            s_carry  = 1'b1;
         end else begin
            s_inc[1] = 1'b1;
         end
      end else begin
         s_inc[0] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= RUN;
      else         state_q <= state_d;
   end

   // btn_mode wins over a timeout landing in the same cycle
   always_comb begin
      state_d = state_q;
      if (mode_ev) begin
         case (state_q)
            RUN:     state_d = SET_HR;
            SET_HR:  state_d = SET_MN;
            default: state_d = RUN;
         endcase
      end else if (timeout) begin
         state_d = RUN;
      end
   end

   always_comb begin
      inc_d = 6'b0;
      clr_d = 6'b0;
      if (run_tick) begin
         inc_d[1:0] = s_inc;
         clr_d[1:0] = s_clr;
         if (s_carry) begin
            inc_d[3:2] = m_inc;
            clr_d[3:2] = m_clr;
            if (m_carry) begin
               inc_d[5:4] = h_inc;
               clr_d[5:4] = h_clr;
            end
         end
      end else if (step && state_q == SET_HR) begin
         inc_d[5:4] = h_inc;
         clr_d[5:4] = h_clr;
      end else if (step && state_q == SET_MN) begin
         inc_d[3:2] = m_inc;
         clr_d[3:2] = m_clr;
      end else if (mode_ev && state_q == SET_MN) begin
         clr_d[1:0] = 2'b11;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         inc         <= 6'b0;
         clr         <= 6'b0;
         busy        <= 1'b0;
         up_q        <= 1'b0;
         rep_q       <= '0;
         to_q        <= '0;
         tick_pend_q <= 1'b0;
      end else begin
         inc  <= inc_d;
         clr  <= clr_d;
         busy <= (|inc) | (|clr);
         up_q <= btn_up;
         if (up_rise || !btn_up || rep_hit) rep_q <= '0;
         else                               rep_q <= rep_q + RW'(1);
         if (state_q == RUN || btn_mode || btn_up) to_q <= '0;
         else if (set_tick)                        to_q <= timeout ? '0 : to_q + TW'(1);
         // a tick landing in the settle cycle is held and served right after
         if (state_q == RUN && tick && busy) tick_pend_q <= 1'b1;
         else if (run_tick)                  tick_pend_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_time_seq_ctrl.sv
// Bench for time_seq_ctrl: digit registers driven by the DUT strobes, abstract clock model, strobe scoreboard.
module tb_time_seq_ctrl;

   localparam int R = 8;
   localparam int T = 10;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       tick = 1'b0;
   logic       btn_mode = 1'b0;
   logic       btn_up = 1'b0;
   logic [5:0] inc, clr;
   logic [1:0] mode;
   logic       busy;
   logic [23:0] dg;
   logic        ld = 1'b0;
   logic [23:0] ld_val = '0;

   int errs = 0;
   int checks = 0;
   int h = 0, m = 0, s = 0;
   int md = 0, to = 0;
   logic [11:0] exp_q[$];

   always #5 clk = ~clk;

   time_seq_ctrl #(.REPEAT_CYCLES(R), .TIMEOUT_TICKS(T)) dut (
      .clk(clk), .resetn(resetn), .tick(tick), .btn_mode(btn_mode), .btn_up(btn_up),
      .hr_t(dg[23:20]), .hr_u(dg[19:16]), .mn_t(dg[15:12]), .mn_u(dg[11:8]),
      .sc_t(dg[7:4]), .sc_u(dg[3:0]),
      .inc(inc), .clr(clr), .mode(mode), .busy(busy)
   );

   // The digit registers the sequencer drives; clr beats inc
   always @(posedge clk) begin
      if (ld) dg <= ld_val;
      else begin
         for (int i = 0; i < 6; i++) begin
            if (clr[i])      dg[i*4 +: 4] <= 4'd0;
            else if (inc[i]) dg[i*4 +: 4] <= dg[i*4 +: 4] + 4'd1;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] digs(input int hh, input int mm, input int ss);
      return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   // Strobes needed to move the registers from one time to another
   function automatic logic [11:0] diff(input logic [23:0] a, input logic [23:0] b);
      logic [5:0] fi, fc;
      fi = '0;
      fc = '0;
      for (int i = 0; i < 6; i++)
         if (a[i*4 +: 4] != b[i*4 +: 4]) begin
            if (b[i*4 +: 4] == 4'd0) fc[i] = 1'b1;
            else                     fi[i] = 1'b1;
         end
      return {fi, fc};
   endfunction

   always @(negedge clk) begin
      if (resetn && (inc != 6'd0 || clr != 6'd0)) begin
         if (exp_q.size() == 0) chk("unexpected_strobe", {20'd0, inc, clr}, 32'd0);
         else                   chk("strobe", {20'd0, inc, clr}, {20'd0, exp_q.pop_front()});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc();
   endtask

   task automatic load(input int hh, input int mm, input int ss);
      h = hh; m = mm; s = ss;
      ld_val = digs(hh, mm, ss);
      ld = 1'b1;
      cyc();
      ld = 1'b0;
   endtask

   task automatic adv_sec();
      logic [23:0] old;
      int t;
      old = digs(h, m, s);
      t = (h * 3600 + m * 60 + s + 1) % 86400;
      h = t / 3600; m = (t / 60) % 60; s = t % 60;
      exp_q.push_back(diff(old, digs(h, m, s)));
   endtask

   task automatic set_step();
      logic [23:0] old;
      old = digs(h, m, s);
      if (md == 1) h = (h + 1) % 24;
      else         m = (m + 1) % 60;
      exp_q.push_back(diff(old, digs(h, m, s)));
   endtask

   task automatic mode_model();
      to = 0;
      if (md == 0) md = 1;
      else if (md == 1) md = 2;
      else begin
         md = 0;
         s = 0;
         exp_q.push_back({6'b000000, 6'b000011});
      end
   endtask

   task automatic do_tick(input bit with_mode);
      bit strobe;
      strobe = (md == 0) || (with_mode && md == 2);
      if (md == 0) adv_sec();
      else if (!with_mode) begin
         to++;
         if (to == T) begin md = 0; to = 0; end
      end
      if (with_mode) mode_model();
      tick = 1'b1; btn_mode = with_mode;
      cyc();
      tick = 1'b0; btn_mode = 1'b0;
      cyc();
      chk("busy_after_strobe", busy, strobe);
      cyc();
      chk("mode", mode, md);
   endtask

   task automatic do_mode(input bit with_up);
      mode_model();
      btn_mode = 1'b1; btn_up = with_up;
      cyc();
      btn_mode = 1'b0; btn_up = 1'b0;
      idle(2);
      chk("mode_after_btn", mode, md);
   endtask

   task automatic up_hold(input int k);
      to = 0;
      if (md != 0) for (int j = 0; j < 1 + (k - 1) / R; j++) set_step();
      btn_up = 1'b1;
      repeat (k) cyc();
      btn_up = 1'b0;
      idle(3);
      chk("mode_after_up", mode, md);
   endtask

   task automatic raw_tick(input logic [23:0] raw, input logic [11:0] e, input int hh, input int mm, input int ss);
      ld_val = raw; ld = 1'b1;
      cyc();
      ld = 1'b0;
      exp_q.push_back(e);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      idle(3);
      h = hh; m = mm; s = ss;
      chk("raw_digits", dg, digs(hh, mm, ss));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int r;
      resetn = 1'b0;
      load(0, 0, 0);
      chk("reset_inc", inc, 6'd0);
      chk("reset_clr", clr, 6'd0);
      chk("reset_mode", mode, 2'd0);
      chk("reset_busy", busy, 1'b0);
      resetn = 1'b1;
      idle(2);

      // carry chains and rollover
      load(12, 34, 9);  do_tick(0);
      load(12, 34, 59); do_tick(0);
      load(23, 59, 59); do_tick(0);
      load(19, 59, 59); do_tick(0);
      load(9, 59, 58);  do_tick(0); do_tick(0);
      // out-of-range digits still roll over
      raw_tick(24'h00000C, {6'b000010, 6'b000001}, 0, 0, 10);
      raw_tick(24'h255959, {6'b000000, 6'b111111}, 0, 0, 0);

      // set hour 23 -> 00, ticks paused
      load(23, 10, 0);
      do_mode(0);
      up_hold(1);
      do_tick(0); do_tick(0);
      // set minutes 59 -> 03 via auto-repeat, leave with seconds cleared
      do_mode(0);
      load(7, 59, 30);
      up_hold(3 * R + 1);
      do_mode(0);
      chk("digits_after_set", dg, digs(7, 3, 0));
      // timeout back to RUN
      do_mode(0);
      for (int i = 0; i < T; i++) do_tick(0);
      chk("timeout_mode", mode, 2'd0);
      // tick with btn_mode in RUN: tick served then SET_HR; then mode+up together
      do_tick(1);
      do_mode(1);
      do_mode(0);

      // tick arriving in the busy cycle is served one cycle late
      load(1, 2, 3);
      adv_sec(); tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
      chk("busy_pend", busy, 1'b1);
      adv_sec(); tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("pend_wait", {inc, clr}, 12'd0);
      cyc();
      chk("pend_served", ({inc, clr} != 12'd0), 1'b1);
      idle(3);

      // reset while a set strobe is on the outputs
      load(4, 5, 6);
      do_mode(0);
      btn_up = 1'b1;
      cyc();
      btn_up = 1'b0;
      chk("strobe_before_reset", ({inc, clr} != 12'd0), 1'b1);
      #2 resetn = 1'b0;
      #1;
      chk("rst_inc", inc, 6'd0);
      chk("rst_clr", clr, 6'd0);
      chk("rst_mode", mode, 2'd0);
      chk("rst_busy", busy, 1'b0);
      md = 0; to = 0;
      @(posedge clk); #1 resetn = 1'b1;
      idle(2);
      chk("digits_after_reset", dg, digs(4, 5, 6));

      // randomized traffic against the abstract clock model
      for (int it = 0; it < 250; it++) begin
         r = $urandom % 10;
         case (r)
            0, 1, 2, 3: do_tick(0);
            4:          do_mode(0);
            5:          up_hold($urandom_range(1, 3 * R + 2));
            6:          do_tick(1);
            7:          do_mode(1);
            8:          load($urandom_range(0, 23), $urandom_range(0, 59),
                             ($urandom % 2) ? $urandom_range(55, 59) : $urandom_range(0, 59));
            default:    idle($urandom_range(1, 4));
         endcase
      end

      idle(5);
      chk("queue_empty", exp_q.size(), 0);
      chk("final_digits", dg, digs(h, m, s));
      chk("final_mode", mode, md);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
